// File: rtl/output_display_pkg.sv
// Shared types and constants for the SAP output stage: FSM states, segment codes and
// the double-dabble nibble adjust.
package output_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/output_display_seg7_decoder.sv
// Combinational BCD digit to 7-segment decoder with a blanking override.
// Zero latency; no flow control.
module seg7_decoder
  import output_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : seg_of(digit);

endmodule

// File: rtl/output_display.sv
// SAP output stage: captures a bus byte, converts it to decimal and scans a 4-digit display.
// Capture to commit takes 10 edges; loads during conversion land in a 1-deep overwrite slot.
module output_display
  import output_display_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_in,
  input  logic       out_load,
  input  logic       signed_mode,
  output logic       busy,
  output logic [7:0] value,
  output logic [6:0] seg,
  output logic [3:0] dig_en
);

  localparam int CW = $clog2(SCAN_DIV);

  state_t      state, state_n;
  logic [2:0]  step_cnt;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        conv_neg;
  logic        pend_vld, pend_sgn;
  logic [7:0]  pend_dat;
  logic [11:0] disp_bcd;
  logic        disp_neg;
  logic [CW-1:0] scan_cnt;
  logic [1:0]  scan_idx, idx_n;

  logic start, use_pend, step, commit, pend_wr, pend_clr;
  logic [7:0] src_dat, src_mag;
  logic src_neg;

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    use_pend = 1'b0;
    step     = 1'b0;
    commit   = 1'b0;
    pend_wr  = 1'b0;
    pend_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (out_load) begin
          start   = 1'b1;
          state_n = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        step    = 1'b1;
        pend_wr = out_load;
        if (step_cnt == 3'd7) state_n = ST_DONE;
      end
      ST_DONE: begin
        commit = 1'b1;
        // A fresh load supersedes whatever was parked in the pending slot.
        if (out_load) begin
          start    = 1'b1;
          pend_clr = 1'b1;
          state_n  = ST_CONVERT;
        end else if (pend_vld) begin
          start    = 1'b1;
          use_pend = 1'b1;
          pend_clr = 1'b1;
          state_n  = ST_CONVERT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign src_dat = use_pend ? pend_dat : bus_in;
  assign src_neg = (use_pend ? pend_sgn : signed_mode) & src_dat[7];
  assign src_mag = src_neg ? (~src_dat + 8'd1) : src_dat;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      value    <= '0;
      step_cnt <= '0;
      bin      <= '0;
      bcd      <= '0;
      conv_neg <= 1'b0;
      pend_vld <= 1'b0;
      pend_sgn <= 1'b0;
      pend_dat <= '0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        value    <= src_dat;
        bin      <= src_mag;
        bcd      <= '0;
        conv_neg <= src_neg;
        step_cnt <= '0;
      end else if (step) begin
        {bcd, bin} <= {bcd_adjust(bcd), bin} << 1;
        step_cnt   <= step_cnt + 3'd1;
      end
      if (commit) begin
        disp_bcd <= bcd;
        disp_neg <= conv_neg;
      end
      if (pend_wr) begin
        pend_vld <= 1'b1;
        pend_dat <= bus_in;
        pend_sgn <= signed_mode;
      end else if (pend_clr) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Scan: dig_en and seg are both derived from the next index so they always change together.
  logic       scan_wrap;
  logic [3:0] dec_dig;
  logic       dec_blank;
  logic [6:0] dec_seg;

  assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));
  assign idx_n     = scan_wrap ? scan_idx + 2'd1 : scan_idx;

  always_comb begin
    dec_dig   = disp_bcd[3:0];
    dec_blank = 1'b0;
    case (idx_n)
      2'd1: begin
        dec_dig   = disp_bcd[7:4];
        dec_blank = (disp_bcd[11:4] == 8'd0);
      end
      2'd2: begin
        dec_dig   = disp_bcd[11:8];
        dec_blank = (disp_bcd[11:8] == 4'd0);
      end
      2'd3: begin
        dec_dig   = 4'd0;
        dec_blank = 1'b1;
      end
      default: ;
    endcase
  end

  seg7_decoder u_dec (
    .digit (dec_dig),
    .blank (dec_blank),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      dig_en   <= 4'b0001;
      seg      <= 7'h3F;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + CW'(1);
      scan_idx <= idx_n;
      dig_en   <= 4'b0001 << idx_n;
      seg      <= (idx_n == 2'd3) ? (disp_neg ? SEG_MINUS : SEG_BLANK) : dec_seg;
    end
  end

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display with a scoreboard of expected display contents.
module tb_output_display;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_in;
  logic       out_load;
  logic       signed_mode;
  logic       busy;
  logic [7:0] value;
  logic [6:0] seg;
  logic [3:0] dig_en;

  typedef struct packed {
    logic [7:0]  val;
    logic [27:0] segs;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   seen42   = 1'b0;
  bit   mon42    = 1'b0;

  output_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_in      (bus_in),
    .out_load    (out_load),
    .signed_mode (signed_mode),
    .busy        (busy),
    .value       (value),
    .seg         (seg),
    .dig_en      (dig_en)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon42 && value == 8'd42) seen42 = 1'b1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] tseg(input int d);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  // Expected {d3,d2,d1,d0} segments computed arithmetically from the byte.
  function automatic logic [27:0] model(input logic [7:0] b, input logic sm);
    int m, h, t, o;
    bit neg;
    logic [6:0] d0, d1, d2, d3;
    neg = sm && b[7];
    m   = neg ? 256 - int'(b) : int'(b);
    h   = m / 100;
    t   = (m / 10) % 10;
    o   = m % 10;
    d0  = tseg(o);
    d1  = (h == 0 && t == 0) ? 7'h00 : tseg(t);
    d2  = (h == 0) ? 7'h00 : tseg(h);
    d3  = neg ? 7'h40 : 7'h00;
    return {d3, d2, d1, d0};
  endfunction

  // Called just after a negedge; returns at the negedge following the capture edge.
  task automatic load(input logic [7:0] b, input logic sm, input bit push);
    bus_in      = b;
    signed_mode = sm;
    out_load    = 1'b1;
    if (push) sb_q.push_back('{val: b, segs: model(b, sm)});
    @(negedge clk);
    out_load = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 100) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic sweep(output logic [27:0] s, output bit bad);
    s   = '0;
    bad = 1'b0;
    @(negedge clk);
    repeat (4 * SCAN_DIV) begin
      case (dig_en)
        4'b0001: s[6:0]   = seg;
        4'b0010: s[13:7]  = seg;
        4'b0100: s[20:14] = seg;
        4'b1000: s[27:21] = seg;
        default: bad = 1'b1;
      endcase
      @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    exp_t e;
    logic [27:0] s;
    bit bad;
    int c;
    wait_idle(c);
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_value"}, 32'(value), 32'(e.val));
      sweep(s, bad);
      check({tag, "_onehot"}, 32'(bad), 32'd0);
      check({tag, "_segs"}, 32'(s), 32'(e.segs));
    end
  endtask

  task automatic align_scan();
    logic [3:0] prev;
    int n;
    n    = 0;
    prev = dig_en;
    @(negedge clk);
    while (!(dig_en == 4'b0001 && prev != 4'b0001) && n < 40) begin
      prev = dig_en;
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("align_timeout", 32'(dig_en), 32'd1);
  endtask

  initial begin
    logic [27:0] s;
    bit bad;
    int c;

    rst         = 1'b1;
    bus_in      = '0;
    out_load    = 1'b0;
    signed_mode = 1'b0;

    // T1: reset state and idle display
    #2;
    check("rst_value", 32'(value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dig_en", 32'(dig_en), 32'd1);
    check("rst_seg", 32'(seg), 32'h3F);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      sweep(s, bad);
      check("t1_onehot", 32'(bad), 32'd0);
      check("t1_segs", 32'(s), 32'(model(8'd0, 1'b0)));
    end
    check("t1_busy", 32'(busy), 32'd0);

    // T2: unsigned 255, busy width
    load(8'd255, 1'b0, 1'b1);
    check("t2_value_capture", 32'(value), 32'hFF);
    check("t2_busy_start", 32'(busy), 32'd1);
    wait_idle(c);
    check("t2_busy_cycles", 32'(c), 32'd9);
    drain("t2");

    // T3: signed extremes
    load(8'h80, 1'b1, 1'b1);
    drain("t3_m128");
    load(8'hFF, 1'b1, 1'b1);
    drain("t3_m1");
    load(8'hFF, 1'b0, 1'b1);
    drain("t3_u255_again");

    // T4: loads during conversion; pending slot keeps only the newest
    mon42 = 1'b1;
    align_scan();
    repeat (6) @(negedge clk);
    load(8'd7, 1'b0, 1'b0);
    @(negedge clk);
    load(8'd42, 1'b0, 1'b0);
    @(negedge clk);
    load(8'd99, 1'b0, 1'b1);
    check("t4_value_hold", 32'(value), 32'd7);
    repeat (5) @(negedge clk);
    check("t4_value_next", 32'(value), 32'd99);
    check("t4_busy_chain", 32'(busy), 32'd1);
    @(negedge clk);
    check("t4_first_dig", 32'(dig_en), 32'd1);
    check("t4_first_seg", 32'(seg), 32'h07);
    drain("t4");
    mon42 = 1'b0;
    check("t4_no42", 32'(seen42), 32'd0);

    // T5: reset mid-conversion
    load(8'd200, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_value", 32'(value), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_dig_en", 32'(dig_en), 32'd1);
    check("t5_seg", 32'(seg), 32'h3F);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_value_after", 32'(value), 32'd0);
    sweep(s, bad);
    check("t5_segs", 32'(s), 32'(model(8'd0, 1'b0)));

    // T6: scan cadence with a load in the middle
    align_scan();
    for (int k = 0; k < 20; k++) begin
      check("t6_dig_en", 32'(dig_en), 32'(4'b0001 << ((k / SCAN_DIV) % 4)));
      if (k == 5) begin
        bus_in      = 8'd5;
        signed_mode = 1'b0;
        out_load    = 1'b1;
        sb_q.push_back('{val: 8'd5, segs: model(8'd5, 1'b0)});
      end else begin
        out_load = 1'b0;
      end
      @(negedge clk);
    end
    out_load = 1'b0;
    drain("t6");

    check("sb_empty_end", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
